// File: rtl/ser_host.sv
// ser_host - host-side driver for the ser serial transceiver.
//
// Buffers outgoing bytes in a TX FIFO and sequences ser's start_xmt/xmt_done
// handshake one byte per frame. Bytes reported by ser on rcv_done are
// captured into an RX FIFO. Both FIFOs face the core logic as valid/ready
// streams. A watchdog aborts a frame whose xmt_done never arrives.
//
// Optional feature: define SER_HOST_STATS_EN to build the 16-bit tx_count /
// rx_count statistics counters. When it is undefined both ports read 0 and
// no counter flops exist.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   tx_data/valid/ready   outgoing byte stream (tx_ready = TX FIFO not full)
//   rx_data/valid/ready   received byte stream, first-word fall-through
//   start_xmt, xmt_byte   to ser: level request and the byte, held per frame
//   xmt_done              from ser: high while the current frame is complete
//   rcv_done, rcv_byte    from ser: one-clk pulse with the received byte
//   rx_overrun            sticky: a received byte was dropped on a full FIFO
//   tx_timeout            sticky: a frame was aborted by the watchdog
//   clr_err               clears both sticky flags (a same-cycle set wins)
//   tx_count, rx_count    frames completed / bytes accepted, wrapping

module ser_host #(
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8,
  parameter int GAP_CYCLES = 20,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        start_xmt,
  output logic [7:0]  xmt_byte,
  input  logic        xmt_done,
  input  logic        rcv_done,
  input  logic [7:0]  rcv_byte,
  output logic        rx_overrun,
  output logic        tx_timeout,
  input  logic        clr_err,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYCLES);

  localparam logic [TX_AW:0]   TX_FULL  = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_FULL  = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  // The RELEASE cycle is the first low cycle of the gap, so GAP itself runs
  // GAP_CYCLES-1 cycles. With IDLE and LOAD that puts the next rise exactly
  // GAP_CYCLES+2 cycles after the fall.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    RELEASE,
    GAP
  } state_t;

  state_t            state;
  logic [WD_W-1:0]   wd_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_push, tx_pop;

  assign tx_ready = (tx_cnt != TX_FULL);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = (state == IDLE) && (tx_cnt != '0);

  // NOTE: FIFO storage has no reset; the pointers and count alone define
  // which entries are valid, and leaving the array unreset keeps it in RAM.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO and capture path (independent of the TX FSM)
  // ---------------------------------------------------------------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_cnt;
  logic             rx_full, rx_push, rx_pop, rx_drop;

  assign rx_valid = (rx_cnt != '0);
  assign rx_full  = (rx_cnt == RX_FULL);
  assign rx_data  = rx_mem[rx_rd_ptr];
  assign rx_pop   = rx_valid & rx_ready;
  // A full FIFO still accepts a byte when the host pops in the same cycle.
  assign rx_push  = rcv_done & (~rx_full | rx_pop);
  assign rx_drop  = rcv_done & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rcv_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit sequencer
  // ---------------------------------------------------------------------
  logic frame_done, frame_abort;

  assign frame_done  = (state == WAIT_DONE) && xmt_done;
  assign frame_abort = (state == WAIT_DONE) && !xmt_done && (wd_cnt == WD_LAST);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_xmt <= 1'b0;
      xmt_byte  <= '0;
      wd_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_pop) begin
            // Byte is loaded a cycle ahead so it is stable when start rises.
            xmt_byte <= tx_mem[tx_rd_ptr];
            state    <= LOAD;
          end
        end
        LOAD: begin
          start_xmt <= 1'b1;
          wd_cnt    <= '0;
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (frame_done || frame_abort) begin
            start_xmt <= 1'b0;
            state     <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RELEASE: begin
          // ser holds xmt_done until it sees start_xmt low.
          if (!xmt_done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          start_xmt <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags: a set event outranks clr_err in the same cycle
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      if (rx_drop)      rx_overrun <= 1'b1;
      else if (clr_err) rx_overrun <= 1'b0;
      if (frame_abort)  tx_timeout <= 1'b1;
      else if (clr_err) tx_timeout <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------
`ifdef SER_HOST_STATS_EN
  logic [15:0] tx_count_q, rx_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      if (frame_done) tx_count_q <= tx_count_q + 1'b1;
      if (rx_push)    rx_count_q <= rx_count_q + 1'b1;
    end
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
`else
  assign tx_count = '0;
  assign rx_count = '0;
`endif

endmodule

// File: tb/tb_ser_host.sv
// tb_ser_host - directed self-checking bench for ser_host.
//
// A small ser model answers start_xmt with xmt_done FRAME clk after the rise
// (or never, when hang is set). Expected TX bytes and RX bytes are queued as
// stimulus is driven and popped when the DUT presents them. Inputs change
// just after the falling edge; outputs are sampled on the falling edge.

module tb_ser_host;

  localparam int TX_DEPTH   = 8;
  localparam int RX_DEPTH   = 8;
  localparam int GAP_CYCLES = 20;
  localparam int TIMEOUT    = 4096;
  localparam int FRAME      = 2880;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start_xmt;
  logic [7:0]  xmt_byte;
  logic        xmt_done;
  logic        rcv_done;
  logic [7:0]  rcv_byte;
  logic        rx_overrun;
  logic        tx_timeout;
  logic        clr_err;
  logic [15:0] tx_count;
  logic [15:0] rx_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         exp_tx = 0;
  int         exp_rx = 0;
  int         low_run = 0;
  logic       hang = 1'b0;
  int         frame_cnt;

  ser_host #(
    .TX_DEPTH   (TX_DEPTH),
    .RX_DEPTH   (RX_DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start_xmt  (start_xmt),
    .xmt_byte   (xmt_byte),
    .xmt_done   (xmt_done),
    .rcv_done   (rcv_done),
    .rcv_byte   (rcv_byte),
    .rx_overrun (rx_overrun),
    .tx_timeout (tx_timeout),
    .clr_err    (clr_err),
    .tx_count   (tx_count),
    .rx_count   (rx_count)
  );

  always #5 clk = ~clk;

  // ser model: xmt_done rises FRAME clk after start_xmt rises and stays high
  // until start_xmt is seen low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 0;
      xmt_done  <= 1'b0;
    end else if (!start_xmt) begin
      frame_cnt <= 0;
      xmt_done  <= 1'b0;
    end else if (!hang) begin
      if (frame_cnt == FRAME - 1) xmt_done <= 1'b1;
      else                        frame_cnt <= frame_cnt + 1;
    end
  end

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef SER_HOST_STATS_EN
    return n[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tx_push(input logic [7:0] b);
    check("tx_ready_before_push", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_q.push_back(b);
  endtask

  // Wait for start_xmt to rise; check the byte was already stable the cycle before.
  task automatic wait_rise(input bit chk_gap);
    logic [7:0] prev_b;
    logic [7:0] e;
    int n;
    prev_b = xmt_byte;
    n = 0;
    while (!start_xmt && n < 200) begin
      prev_b = xmt_byte;
      @(negedge clk);
      n++;
      low_run++;
    end
    check("start_rise_seen", start_xmt, 1'b1);
    e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
    check("xmt_byte_before_rise", prev_b, e);
    check("xmt_byte_at_rise", xmt_byte, e);
    if (chk_gap) check("gap_low_cycles_ok", low_run >= GAP_CYCLES, 1'b1);
  endtask

  task automatic wait_fall(input int limit, output int high, output logic prev_done);
    high = 0;
    prev_done = 1'b0;
    while (start_xmt && high < limit) begin
      prev_done = xmt_done;
      @(negedge clk);
      high++;
    end
    check("start_fall_seen", start_xmt, 1'b0);
    low_run = 1;
  endtask

  task automatic rx_cycle(input bit push, input logic [7:0] b, input bit pop);
    int occ;
    occ = rx_q.size();
    if (pop) begin
      check("rx_valid_at_pop", rx_valid, 1'b1);
      if (occ > 0) check("rx_data_at_pop", rx_data, rx_q.pop_front());
    end
    if (push && (occ < RX_DEPTH || pop)) begin
      rx_q.push_back(b);
      exp_rx++;
    end
    rcv_done = push;
    rcv_byte = b;
    rx_ready = pop;
    @(posedge clk);
    @(negedge clk);
    rcv_done = 1'b0;
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    int   high;
    logic pd;

    rst_n    = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    rcv_done = 1'b0;
    rcv_byte = '0;
    clr_err  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_start_xmt", start_xmt, 1'b0);
    check("rst_xmt_byte", xmt_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_overrun", rx_overrun, 1'b0);
    check("rst_tx_timeout", tx_timeout, 1'b0);
    check("rst_tx_count", tx_count, 16'd0);
    check("rst_rx_count", rx_count, 16'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0xA5
    tx_push(8'hA5);
    wait_rise(1'b0);
    wait_fall(6000, high, pd);
    check("a5_high_until_done", high >= FRAME, 1'b1);
    check("a5_done_before_fall", pd, 1'b1);
    exp_tx++;
    check("a5_tx_count", tx_count, cnt_exp(exp_tx));

    // Back-to-back 0x11, 0x22, 0x33
    tx_push(8'h11);
    tx_push(8'h22);
    tx_push(8'h33);
    for (int i = 0; i < 3; i++) begin
      wait_rise(i > 0);
      wait_fall(6000, high, pd);
      check("b2b_done_before_fall", pd, 1'b1);
      exp_tx++;
      check("b2b_tx_count", tx_count, cnt_exp(exp_tx));
    end

    // Watchdog abort of 0x5A
    hang = 1'b1;
    tx_push(8'h5A);
    wait_rise(1'b0);
    wait_fall(6000, high, pd);
    check("wd_high_cycles", high, TIMEOUT);
    check("wd_tx_timeout_set", tx_timeout, 1'b1);
    check("wd_tx_count_unchanged", tx_count, cnt_exp(exp_tx));
    hang = 1'b0;
    pulse_clr();
    check("wd_tx_timeout_cleared", tx_timeout, 1'b0);

    // RX overrun: nine bytes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) rx_cycle(1'b1, 8'(i), 1'b0);
    check("ovr_rx_valid", rx_valid, 1'b1);
    check("ovr_rx_data_head", rx_data, 8'h01);
    check("ovr_rx_overrun", rx_overrun, 1'b1);
    check("ovr_rx_count", rx_count, cnt_exp(exp_rx));
    for (int i = 0; i < RX_DEPTH; i++) rx_cycle(1'b0, 8'h00, 1'b1);
    check("ovr_drained_empty", rx_valid, 1'b0);
    pulse_clr();
    check("ovr_cleared", rx_overrun, 1'b0);

    // Simultaneous push and pop on a full RX FIFO
    for (int i = 0; i < RX_DEPTH; i++) rx_cycle(1'b1, 8'(8'h10 + i), 1'b0);
    rx_cycle(1'b1, 8'h18, 1'b1);
    check("full_pp_no_overrun", rx_overrun, 1'b0);
    check("full_pp_new_head", rx_data, 8'h11);
    for (int i = 0; i < RX_DEPTH; i++) rx_cycle(1'b0, 8'h00, 1'b1);
    check("full_pp_drained_empty", rx_valid, 1'b0);
    check("full_pp_rx_count", rx_count, cnt_exp(exp_rx));

    // Reset in the middle of a frame with RX data and a sticky flag present
    hang = 1'b1;
    tx_push(8'h77);
    wait_rise(1'b0);
    for (int i = 1; i <= 9; i++) rx_cycle(1'b1, 8'(8'h40 + i), 1'b0);
    check("mid_in_wait_done", start_xmt, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_start_xmt", start_xmt, 1'b0);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_rx_overrun", rx_overrun, 1'b0);
    check("mid_rst_tx_timeout", tx_timeout, 1'b0);
    check("mid_rst_xmt_byte", xmt_byte, 8'h00);
    check("mid_rst_rx_count", rx_count, 16'd0);
    tx_q.delete();
    rx_q.delete();
    hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", start_xmt, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
